// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle, with the 64-bit result held in HI/LO and one-cycle done/divide-by-zero pulses.
module mult_div_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MultCtrl,
  input  logic              DivCtrl,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              MultOut,
  output logic              DivOut,
  output logic              divZero,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  typedef enum logic [2:0] {
    StIdle,
    StMultRun,
    StDivRun,
    StDone,
    StWaitRel
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] acc_q;    // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [DATA_W-1:0]   opnd_q;   // multiplicand or divisor magnitude
  logic                neg_lo_q;
  logic                neg_hi_q;

  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_trial;
  logic [DATA_W:0]     div_diff;
  logic [2*DATA_W-1:0] div_next;
  logic [2*DATA_W-1:0] mul_res;
  logic [DATA_W-1:0]   div_quo;
  logic [DATA_W-1:0]   div_rem;

  always_comb begin
    mag_a     = A[DATA_W-1] ? -A : A;
    mag_b     = B[DATA_W-1] ? -B : B;
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
    div_trial = acc_q[2*DATA_W-1:DATA_W-1];
    div_diff  = div_trial - {1'b0, opnd_q};
    // Top bit of the difference is the borrow: set means the trial subtraction failed.
    if (!div_diff[DATA_W]) begin
      div_next = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    end else begin
      div_next = {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    end
    mul_res = neg_lo_q ? -acc_q : acc_q;
    div_quo = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    div_rem = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      MultOut  <= 1'b0;
      DivOut   <= 1'b0;
      divZero  <= 1'b0;
    end else begin
      MultOut <= 1'b0;
      DivOut  <= 1'b0;
      divZero <= 1'b0;
      case (state_q)
        StIdle: begin
          if (MultCtrl) begin
            acc_q    <= {{DATA_W{1'b0}}, mag_b};
            opnd_q   <= mag_a;
            neg_lo_q <= A[DATA_W-1] ^ B[DATA_W-1];
            neg_hi_q <= A[DATA_W-1] ^ B[DATA_W-1];
            cnt_q    <= '0;
            state_q  <= StMultRun;
          end else if (DivCtrl) begin
            if (B != '0) begin
              acc_q    <= {{DATA_W{1'b0}}, mag_a};
              opnd_q   <= mag_b;
              neg_lo_q <= A[DATA_W-1] ^ B[DATA_W-1];
              neg_hi_q <= A[DATA_W-1];
              cnt_q    <= '0;
              state_q  <= StDivRun;
            end else begin
              divZero <= 1'b1;
              state_q <= StWaitRel;
            end
          end
        end
        StMultRun: begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            HI      <= mul_res[2*DATA_W-1:DATA_W];
            LO      <= mul_res[DATA_W-1:0];
            MultOut <= 1'b1;
            state_q <= StDone;
          end else begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDivRun: begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            HI      <= div_rem;
            LO      <= div_quo;
            DivOut  <= 1'b1;
            state_q <= StDone;
          end else begin
            acc_q <= div_next;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: state_q <= StWaitRel;
        StWaitRel: begin
          // Wait for both start levels to drop so a held level cannot retrigger.
          if (!MultCtrl && !DivCtrl) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed and random multiply/divide operations compared every cycle
// against an arithmetic reference model with spec-level latency.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MultCtrl = 1'b0;
  logic        DivCtrl = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        MultOut;
  logic        DivOut;
  logic        divZero;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int passed = 0;

  mult_div_unit #(
    .DATA_W(32),
    .CNT_W (6)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .MultCtrl(MultCtrl),
    .DivCtrl (DivCtrl),
    .A       (A),
    .B       (B),
    .MultOut (MultOut),
    .DivOut  (DivOut),
    .divZero (divZero),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  // {remainder, quotient}; 64-bit signed division truncates toward zero.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Reference model: 0 idle, 1 busy, 2 done cycle, 3 waiting for release.
  int          phase = 0;
  int          left = 0;
  logic [31:0] r_hi, r_lo;
  logic        r_div;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_mo = 1'b0;
  logic        m_do = 1'b0;
  logic        m_dz = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= 0;
      left  <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
      m_mo  <= 1'b0;
      m_do  <= 1'b0;
      m_dz  <= 1'b0;
    end else begin
      m_mo <= 1'b0;
      m_do <= 1'b0;
      m_dz <= 1'b0;
      case (phase)
        0: begin
          if (MultCtrl) begin
            {r_hi, r_lo} <= mul_ref(A, B);
            r_div <= 1'b0;
            left  <= 33;
            phase <= 1;
          end else if (DivCtrl) begin
            if (B == 32'd0) begin
              m_dz  <= 1'b1;
              phase <= 3;
            end else begin
              {r_hi, r_lo} <= div_ref(A, B);
              r_div <= 1'b1;
              left  <= 33;
              phase <= 1;
            end
          end
        end
        1: begin
          left <= left - 1;
          if (left == 1) begin
            m_hi  <= r_hi;
            m_lo  <= r_lo;
            m_mo  <= !r_div;
            m_do  <= r_div;
            phase <= 2;
          end
        end
        2: phase <= 3;
        default: if (!MultCtrl && !DivCtrl) phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if ($time > 20) begin
      check("outputs{mo,do,dz,hi,lo}", {MultOut, DivOut, divZero, HI, LO},
            {m_mo, m_do, m_dz, m_hi, m_lo});
    end
  end

  // kind: 0 mult, 1 div, 2 both start levels together.
  task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output int lat, output logic [2:0] seen);
    @(negedge clk);
    A = a;
    B = b;
    MultCtrl = (kind != 1);
    DivCtrl  = (kind != 0);
    lat  = -1;
    seen = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (MultOut || DivOut || divZero) begin
        lat  = i;
        seen = {MultOut, DivOut, divZero};
        break;
      end
      if (scramble) begin
        A = $urandom;
        B = $urandom;
      end
    end
    @(negedge clk);
    MultCtrl = 1'b0;
    DivCtrl  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          pulses;
    int          kind;
    logic [2:0]  seen;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_state", {MultOut, DivOut, divZero, HI, LO}, '0);

    run_op(0, 32'd7, 32'hFFFF_FFFD, 1'b0, lat, seen);
    check("mult_latency", lat, 34);
    check("mult_pulse", seen, 3'b100);
    check("mult_7x-3", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, seen);
    check("mult_min_sq", {HI, LO}, 64'h4000_0000_0000_0000);
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, seen);
    check("mult_m1_sq", {HI, LO}, 64'h0000_0000_0000_0001);

    run_op(1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, seen);
    check("div_latency", lat, 34);
    check("div_pulse", seen, 3'b010);
    check("div_-7/2", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(1, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, seen);
    check("div_7/-2", {HI, LO}, 64'h0000_0001_FFFF_FFFD);
    run_op(1, 32'd100, 32'd7, 1'b0, lat, seen);
    check("div_100/7", {HI, LO}, {32'd2, 32'd14});

    run_op(0, 32'd7, 32'hFFFF_FFFD, 1'b0, lat, seen);
    run_op(1, 32'd55, 32'd0, 1'b0, lat, seen);
    check("divzero_latency", lat, 1);
    check("divzero_pulse", seen, 3'b001);
    check("divzero_hilo_kept", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(0, 32'd3, 32'd5, 1'b0, lat, seen);
    check("mult_after_divzero", {seen, HI, LO}, {3'b100, 32'd0, 32'd15});

    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, seen);
    check("div_overflow", {seen, HI, LO}, {3'b010, 32'd0, 32'h8000_0000});

    // Abort a multiply with an asynchronous reset at edge 10.
    @(negedge clk);
    A = 32'd5;
    B = 32'd9;
    MultCtrl = 1'b1;
    repeat (11) @(posedge clk);
    #1 reset = 1'b0;
    #1 check("async_reset_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    MultCtrl = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (MultOut || DivOut || divZero) pulses++;
    end
    check("no_pulse_after_abort", pulses, 0);

    run_op(2, 32'd6, 32'hFFFF_FFFC, 1'b0, lat, seen);
    check("priority_mult", {seen, HI, LO}, {3'b100, 64'hFFFF_FFFF_FFFF_FFE8});

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      a = pick();
      b = pick();
      run_op(kind, a, b, 1'b1, lat, seen);
      if (kind == 1 && b == 32'd0) begin
        check("rand_divzero", {lat, seen}, {32'd1, 3'b001});
      end else if (kind == 1) begin
        check("rand_div", {lat, seen, HI, LO}, {32'd34, 3'b010, div_ref(a, b)});
      end else begin
        check("rand_mult", {lat, seen, HI, LO}, {32'd34, 3'b100, mul_ref(a, b)});
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide responder for the MIPS datapath.
- Answers the control unit's MultCtrl/DivCtrl start levels and returns MultOut/DivOut done pulses plus a divZero exception flag.
- Holds the 64-bit result in HI/LO, which the control unit later reads through MFHI/MFLO.
- Operands come from the A/B register outputs of the datapath.

Parameters:
DATA_W, 32, operand width; HI/LO width.
CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
MultCtrl  input  1  multiply start level; held high by control until MultOut is seen.
DivCtrl  input  1  divide start level; held high by control until DivOut or divZero is seen.
A  input  DATA_W  operand rs (multiplicand / dividend).
B  input  DATA_W  operand rt (multiplier / divisor).
MultOut  output  1  one-cycle pulse: multiply result valid in HI/LO.
DivOut  output  1  one-cycle pulse: divide result valid in HI/LO.
divZero  output  1  one-cycle pulse: divide by zero detected.
HI  output  DATA_W  mult: product[63:32]; div: remainder.
LO  output  DATA_W  mult: product[31:0]; div: quotient.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; counter=0; internal accumulators=0.
  - HI=0, LO=0; MultOut=0, DivOut=0, divZero=0.
  - Reset applied mid-operation aborts the operation. No done pulse follows.
- States: IDLE, MULT_RUN, DIV_RUN, DONE, WAIT_REL.
- IDLE:
  - MultCtrl=1 → latch A, B; state=MULT_RUN; counter=0.
  - Otherwise DivCtrl=1 and B≠0 → latch A, B; state=DIV_RUN.
  - Otherwise DivCtrl=1 and B=0 → divZero=1 for one cycle; HI/LO unchanged; state=WAIT_REL.
  - MultCtrl has priority when both are high on the same edge.
- Operand handling: operands are converted to magnitudes. The result sign is computed at accept: prod sign = A[31]^B[31]; quotient sign = A[31]^B[31]; remainder sign = A[31].
- MULT_RUN: unsigned shift-add, one multiplier bit per cycle, DATA_W cycles. After the last iteration, state=DONE.
- DIV_RUN: unsigned restoring division, one quotient bit per cycle, DATA_W cycles. After the last iteration, state=DONE.
- DONE (one cycle):
  - On entry edge: sign-corrected results are written to HI/LO.
  - The matching done output (MultOut or DivOut) is 1 for exactly this cycle.
  - Next state: WAIT_REL.
- WAIT_REL: stay until MultCtrl=0 and DivCtrl=0, then go to IDLE. This prevents re-triggering on a held start level.
- Latency: accept edge = edge 0. The done pulse is high in the cycle after edge DATA_W+1 (33 edges for DATA_W=32). HI/LO are valid from that same cycle.
- HI/LO change only on the DONE entry edge or on reset. They hold their value otherwise, including during RUN.
- Start levels seen during MULT_RUN, DIV_RUN or DONE are ignored. A change of A/B during RUN has no effect.
- Arithmetic rules:
  - Product is the full 64-bit two's complement result; no overflow.
  - Quotient truncates toward zero. Remainder takes the dividend's sign; |rem| < |B|.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Wraps; no exception.
  - |0x80000000| is treated as unsigned 2^31.
- Outputs are registered and there is no combinational path from inputs to outputs.

Test Plan:
- Mult: A=7, B=0xFFFFFFFD (-3), MultCtrl held high until MultOut → MultOut pulse after 33 edges; HI=0xFFFFFFFF, LO=0xFFFFFFEB. Control keeps MultCtrl high one extra cycle → no second operation.
- Mult extreme: A=B=0x80000000 → HI=0x40000000, LO=0x00000000; A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0, LO=1.
- Div signs:
  - A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=7, B=-2 → LO=0xFFFFFFFD, HI=1.
  - A=100, B=7 → LO=14, HI=2.
  - In each case DivOut is one cycle and MultOut stays 0.
- Div by zero: HI/LO preloaded by a prior mult; DivCtrl=1, B=0 → divZero pulse on the next cycle, DivOut never asserted, HI/LO unchanged; a later mult is still accepted normally.
- Overflow case: A=0x80000000, B=0xFFFFFFFF div → LO=0x80000000, HI=0, no divZero.
- Reset mid-operation and priority:
  - reset=0 asserted at edge 10 of a mult → HI/LO=0 immediately (asynchronous), no MultOut afterwards.
  - After release, MultCtrl and DivCtrl raised together → the multiply is performed.
